// File: rtl/tsense_sr_pkg.sv
// ----------------------------------------------------------------------------
// tsense_sr_pkg
// Shared definitions for the temperature-sense result shift-register reader:
// FSM state encoding, minimum shift-clock half-period, and the frame length
// derived from the data width.
//
// Build option: TSENSE_SR_PARITY_EN adds one trailing even-parity bit to
// every frame.
// ----------------------------------------------------------------------------
package tsense_sr_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Two synchroniser flops plus one settle cycle must fit inside HIGH.
    localparam int MIN_HALF_PER = 3;

`ifdef TSENSE_SR_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Number of shift_clk_o pulses per frame.
    function automatic int frame_len(input int data_w);
        return data_w + PARITY_BITS;
    endfunction

endpackage

// File: rtl/tsense_sync2.sv
// ----------------------------------------------------------------------------
// tsense_sync2
// Generic two-flop synchroniser for signals asynchronous to clk_i.
//
// Ports:
//   clk_i  destination clock
//   rst_i  asynchronous active-high reset (flops clear to 0)
//   d_i    asynchronous input
//   q_o    synchronised output, two clk_i cycles of latency
// ----------------------------------------------------------------------------
module tsense_sync2 #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // NOTE: flop state uses non-blocking assignments so every flop samples
    // the pre-edge value of its source, which is what makes this a chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/tsense_sr_reader.sv
// ----------------------------------------------------------------------------
// tsense_sr_reader
// Reads the temperature-sense serial result register: generates shift_clk_o,
// samples the synchronised serial line at the end of each high phase,
// assembles a DATA_W-bit word and offers it on a valid/ready handshake.
//
// Build option: TSENSE_SR_PARITY_EN - frame carries a trailing even-parity
// bit and parity_err_o reports its check; otherwise parity_err_o is 0.
//
// Ports:
//   wb_clk_i       clock
//   wb_rst_i       asynchronous active-high reset
//   start_i        one-cycle request for a frame (ignored while busy)
//   sr_in          serial data from the pad, asynchronous
//   shift_clk_o    shift clock to the sender (sender updates on its rise)
//   busy_o         frame in progress
//   data_o         last completed word
//   valid_o        data_o holds an unconsumed word
//   ready_i        consumer accepts on valid_o && ready_i
//   overrun_o      sticky: a word completed over an unconsumed one
//   clr_overrun_i  clears overrun_o (a simultaneous set wins)
//   parity_err_o   parity check result of the last word
// ----------------------------------------------------------------------------
module tsense_sr_reader
    import tsense_sr_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int HALF_PER  = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic              sr_in,
    output logic              shift_clk_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              overrun_o,
    input  logic              clr_overrun_i,
    output logic              parity_err_o
);

    // Half-periods shorter than the synchroniser latency would sample stale
    // data, so they are raised to the minimum.
    localparam int HALF_EFF = (HALF_PER < MIN_HALF_PER) ? MIN_HALF_PER : HALF_PER;
    localparam int FRAME    = frame_len(DATA_W);
    localparam int PH_W     = $clog2(HALF_EFF);
    localparam int CNT_W    = 6;

    logic              sr_sync;

    logic [1:0]        state_q,     state_d;
    logic [PH_W-1:0]   phase_q,     phase_d;
    logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [DATA_W-1:0] shreg_q,     shreg_d;
    logic [DATA_W-1:0] data_q,      data_d;
    logic              valid_q,     valid_d;
    logic              overrun_q,   overrun_d;
    logic              shift_clk_q, shift_clk_d;
    logic              busy_q,      busy_d;
`ifdef TSENSE_SR_PARITY_EN
    logic              par_q,       par_d;
    logic              perr_q,      perr_d;
`endif

    logic              phase_last;
    logic [DATA_W-1:0] shreg_shift;

    tsense_sync2 #(.W(1)) u_sr_sync (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .d_i   (sr_in),
        .q_o   (sr_sync)
    );

    assign phase_last  = (phase_q == PH_W'(HALF_EFF - 1));
    assign shreg_shift = (MSB_FIRST != 0) ? {shreg_q[DATA_W-2:0], sr_sync}
                                          : {sr_sync, shreg_q[DATA_W-1:1]};

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through
        // the case below can leave one unassigned and infer a latch.
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
`ifdef TSENSE_SR_PARITY_EN
        par_d     = par_q;
        perr_d    = perr_q;
`endif

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_LOW;
                    phase_d   = '0;
                    bit_cnt_d = '0;
                end
            end
            ST_LOW: begin
                if (phase_last) begin
                    phase_d = '0;
                    state_d = ST_HIGH;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_HIGH: begin
                if (phase_last) begin
                    // Last high cycle: the sender's bit has had the whole
                    // high phase to cross the synchroniser.
                    phase_d   = '0;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
`ifdef TSENSE_SR_PARITY_EN
                    if (bit_cnt_q == CNT_W'(DATA_W)) begin
                        par_d = sr_sync;
                    end else begin
                        shreg_d = shreg_shift;
                    end
`else
                    shreg_d = shreg_shift;
`endif
                    state_d = (bit_cnt_q == CNT_W'(FRAME - 1)) ? ST_DONE : ST_LOW;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_DONE: begin
                data_d  = shreg_q;
                valid_d = 1'b1;
                // An accept in this same cycle consumes the old word, so
                // only an unaccepted pending word counts as overrun.
                if (valid_q && !ready_i) begin
                    overrun_d = 1'b1;
                end
`ifdef TSENSE_SR_PARITY_EN
                perr_d = (^shreg_q) ^ par_q;
`endif
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they are glitch free.
        shift_clk_d = (state_d == ST_HIGH);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            shift_clk_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef TSENSE_SR_PARITY_EN
            par_q       <= 1'b0;
            perr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            shift_clk_q <= shift_clk_d;
            busy_q      <= busy_d;
`ifdef TSENSE_SR_PARITY_EN
            par_q       <= par_d;
            perr_q      <= perr_d;
`endif
        end
    end

    assign shift_clk_o = shift_clk_q;
    assign busy_o      = busy_q;
    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign overrun_o   = overrun_q;
`ifdef TSENSE_SR_PARITY_EN
    assign parity_err_o = perr_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_tsense_sr_reader.sv
// ----------------------------------------------------------------------------
// tb_tsense_sr_reader
// Two readers share control inputs: dut_a (MSB first) and dut_b (LSB first),
// each fed by its own sender model. Expected words, overrun and valid come
// from a word-level handshake model; timing from the frame arithmetic.
// ----------------------------------------------------------------------------
module tb_tsense_sr_reader;
    import tsense_sr_pkg::*;

    localparam int DW    = 16;
    localparam int H     = 4;
    localparam int FRAME = frame_len(DW);
    localparam int LAT   = 2 * H * FRAME + 1;

    logic clk = 1'b0;
    logic rst, start, ready, clr;
    logic sr_a = 1'b0;
    logic sr_b = 1'b0;

    logic          sck_a, busy_a, valid_a, ovr_a, perr_a;
    logic          sck_b, busy_b, valid_b, ovr_b, perr_b;
    logic [DW-1:0] data_a, data_b;

    always #5 clk = ~clk;

    tsense_sr_reader #(.DATA_W(DW), .HALF_PER(H), .MSB_FIRST(1)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .sr_in(sr_a),
        .shift_clk_o(sck_a), .busy_o(busy_a), .data_o(data_a), .valid_o(valid_a),
        .ready_i(ready), .overrun_o(ovr_a), .clr_overrun_i(clr), .parity_err_o(perr_a)
    );

    tsense_sr_reader #(.DATA_W(DW), .HALF_PER(H), .MSB_FIRST(0)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .sr_in(sr_b),
        .shift_clk_o(sck_b), .busy_o(busy_b), .data_o(data_b), .valid_o(valid_b),
        .ready_i(ready), .overrun_o(ovr_b), .clr_overrun_i(clr), .parity_err_o(perr_b)
    );

    // ---------------- sender models and pulse monitors ----------------
    logic tx_a [0:DW];
    logic tx_b [0:DW];
    int   pulses_a = 0, pulses_b = 0, base_a = 0, base_b = 0;
    int   run_a = 0, bad_w_a = 0, base_bw = 0;

    // Sender drives the next frame bit on each rising shift clock.
    always @(posedge sck_a) begin
        pulses_a <= pulses_a + 1;
        if (pulses_a - base_a < FRAME) sr_a <= tx_a[pulses_a - base_a];
    end
    always @(posedge sck_b) begin
        pulses_b <= pulses_b + 1;
        if (pulses_b - base_b < FRAME) sr_b <= tx_b[pulses_b - base_b];
    end

    // Every completed high phase must last exactly H clock cycles.
    always @(negedge clk) begin
        if (sck_a) begin
            run_a <= run_a + 1;
        end else begin
            if (run_a != 0 && run_a != H) bad_w_a <= bad_w_a + 1;
            run_a <= 0;
        end
    end

    // ---------------- scoreboard ----------------
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic pend   = 1'b0;   // model: an unconsumed word is held
    logic ovr_m  = 1'b0;   // model: sticky overrun

    typedef struct {
        logic [15:0] word;
        logic        clr_before;
        logic        accept;
        logic        exp_ovr;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic begin_frame(input logic [15:0] w, input logic pbit);
        for (int i = 0; i < DW; i++) begin
            tx_a[i] = w[DW-1-i];
            tx_b[i] = w[i];
        end
        tx_a[DW] = pbit;
        tx_b[DW] = pbit;
        base_a   = pulses_a;
        base_b   = pulses_b;
        base_bw  = bad_w_a;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [15:0] w, input logic pbit,
                             input logic acc_done, input int mid_start);
        int   lat;
        logic exp_pe;
        begin_frame(w, pbit);
        lat = 0;
        while (busy_a && lat < LAT + 50) begin
            @(negedge clk);
            lat++;
            start = (lat == mid_start);
            ready = acc_done && (lat == LAT - 1);
        end
        start = 1'b0;
        ready = 1'b0;
        if (pend && !acc_done) ovr_m = 1'b1;
        pend = 1'b1;
`ifdef TSENSE_SR_PARITY_EN
        exp_pe = (^w) ^ pbit;
`else
        exp_pe = 1'b0;
`endif
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        check({tag, "_pulses_a"}, 32'(pulses_a - base_a), 32'(FRAME));
        check({tag, "_pulses_b"}, 32'(pulses_b - base_b), 32'(FRAME));
        check({tag, "_high_width"}, 32'(bad_w_a - base_bw), 32'd0);
        check({tag, "_data_a"}, 32'(data_a), 32'(w));
        check({tag, "_data_b"}, 32'(data_b), 32'(w));
        check({tag, "_valid"}, {30'd0, valid_a, valid_b}, 32'b11);
        check({tag, "_overrun"}, {30'd0, ovr_a, ovr_b}, {30'd0, ovr_m, ovr_m});
        check({tag, "_parity_err"}, {30'd0, perr_a, perr_b}, {30'd0, exp_pe, exp_pe});
    endtask

    task automatic accept_word(input string tag);
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;
        pend = 1'b0;
        check({tag, "_valid_clr"}, {30'd0, valid_a, valid_b}, 32'd0);
    endtask

    task automatic clear_ovr(input string tag);
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        ovr_m = 1'b0;
        check({tag, "_ovr_clr"}, {30'd0, ovr_a, ovr_b}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          busy_cnt;
        logic [15:0] w;
        logic        acc;
        logic        cl;

        vecs[0] = '{16'hA5C3, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{16'h1234, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'h00FF, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{16'hFFFF, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'h8001, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; ready = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs_a", 32'({sck_a, busy_a, valid_a, ovr_a, perr_a, data_a}), 32'd0);
        check("reset_outputs_b", 32'({sck_b, busy_b, valid_b, ovr_b, perr_b, data_b}), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        // Basic frame: 16 pulses of 4 cycles, valid 129 cycles after start.
        run_frame("a5c3", 16'hA5C3, ^16'hA5C3, 1'b0, -1);
        accept_word("a5c3");

        // Table of frames exercising the handshake and overrun rules.
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].clr_before) clear_ovr($sformatf("vec%0d", i));
            run_frame($sformatf("vec%0d", i), vecs[i].word, ^vecs[i].word, 1'b0, -1);
            check($sformatf("vec%0d_exp_ovr", i), 32'(ovr_a), 32'(vecs[i].exp_ovr));
            if (vecs[i].accept) accept_word($sformatf("vec%0d", i));
        end

        // Overrun then clear: data is the newer word and stays presented.
        run_frame("ovr1", 16'h1234, ^16'h1234, 1'b0, -1);
        run_frame("ovr2", 16'h00FF, ^16'h00FF, 1'b0, -1);
        check("ovr_set", 32'(ovr_a), 32'd1);
        clear_ovr("ovr");
        check("ovr_data_held", 32'({valid_a, data_a}), 32'({1'b1, 16'h00FF}));
        accept_word("ovr");

        // Accept in the same cycle as the DONE load: no overrun, new data.
        run_frame("acc1", 16'h1357, ^16'h1357, 1'b0, -1);
        run_frame("acc_done", 16'h2468, ^16'h2468, 1'b1, -1);
        accept_word("acc_done");

        // start_i during a frame is neither honoured nor queued.
        run_frame("midstart", 16'hC0DE, ^16'hC0DE, 1'b0, 10);
        accept_word("midstart");
        busy_cnt = 0;
        repeat (LAT + 10) begin
            @(negedge clk);
            if (busy_a) busy_cnt++;
        end
        check("midstart_no_requeue", 32'(busy_cnt), 32'd0);
        check("midstart_single_valid", 32'(valid_a), 32'd0);

        // Asynchronous reset at bit 7 with a word still pending.
        run_frame("pre_rst", 16'h5A5A, ^16'h5A5A, 1'b0, -1);
        begin_frame(16'hBEEF, ^16'hBEEF);
        lat = 0;
        while (pulses_a - base_a < 7 && lat < LAT) begin
            @(negedge clk);
            lat++;
        end
        check("rst_reached_bit7", 32'(pulses_a - base_a), 32'd7);
        check("rst_pre_state", 32'({sck_a, busy_a, valid_a}), 32'b111);
        rst = 1'b1;
        #1;
        check("rst_immediate_a", 32'({sck_a, busy_a, valid_a}), 32'd0);
        check("rst_immediate_b", 32'({sck_b, busy_b, valid_b}), 32'd0);
        pend  = 1'b0;
        ovr_m = 1'b0;
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        run_frame("beef", 16'hBEEF, ^16'hBEEF, 1'b0, -1);
        accept_word("beef");

        // Randomised frames against the word-level model.
        for (int i = 0; i < 10; i++) begin
            w   = 16'($urandom);
            acc = 1'($urandom_range(0, 1));
            cl  = 1'($urandom_range(0, 1));
            if (cl) clear_ovr($sformatf("rnd%0d", i));
            run_frame($sformatf("rnd%0d", i), w, ^w, 1'b0, -1);
            if (acc) accept_word($sformatf("rnd%0d", i));
        end

`ifdef TSENSE_SR_PARITY_EN
        // Bad parity bit then good parity bit on the same data.
        if (pend) accept_word("par_pre");
        run_frame("par_bad", 16'h0001, 1'b0, 1'b0, -1);
        check("par_bad_flag", 32'(perr_a), 32'd1);
        accept_word("par_bad");
        run_frame("par_good", 16'h0001, 1'b1, 1'b0, -1);
        check("par_good_flag", 32'(perr_a), 32'd0);
        accept_word("par_good");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tsense_sr_reader.md
Name: tsense_sr_reader

Overview:
Host-side reader for the temperature-sense digital block's serial result shift register. It generates the shift clock, samples the serial result line from the pad, and assembles a DATA_W-bit count word. The word is presented to the management side on a valid/ready handshake. Sits in the user project area, on the wb_clk_i domain, between the io pads and the Wishbone register file.

Parameters:
DATA_W, 16, bits per result frame (counter width); legal range 4..32
HALF_PER, 4, shift_clk_o half-period in wb_clk_i cycles; must be >=3 to cover the input synchroniser latency
MSB_FIRST, 1, 1: first received bit lands in data_o[DATA_W-1]; 0: first bit lands in data_o[0]

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  asynchronous, active-high reset
start_i  in  1  single-cycle pulse that requests one frame read
sr_in  in  1  serial result from pad, asynchronous to wb_clk_i
shift_clk_o  out  1  generated shift clock to the sender
busy_o  out  1  high while a frame is in progress
data_o  in/out n/a: out  DATA_W  last completed word
valid_o  out  1  data_o holds an unconsumed word
ready_i  in  1  consumer accepts the word on valid_o&&ready_i
overrun_o  out  1  sticky flag: a word completed while the previous word was still unconsumed
clr_overrun_i  in  1  clears overrun_o
parity_err_o  out  1  see Optional Feature

Behaviour:
- Reset (async, wb_rst_i=1): all outputs 0, shift_clk_o=0, FSM=IDLE, bit counter=0, shift register=0. Takes effect immediately, including mid-frame. The partial word is discarded and no valid is produced.
- sr_in passes through a 2-flop synchroniser (sr_sync) before any use.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE: shift_clk_o=0, busy_o=0. start_i=1 -> LOW, with phase counter=0 and bit counter=0.
- LOW: shift_clk_o=0 for HALF_PER cycles, then -> HIGH.
- HIGH: shift_clk_o=1 for HALF_PER cycles.
  - The sender updates its output on the rising edge of shift_clk_o.
  - The reader samples sr_sync on the last cycle of HIGH.
  - After sampling, the bit counter increments. If bit counter == DATA_W-1 at the sample, go -> DONE; otherwise go -> LOW.
- DONE (1 cycle): shift_clk_o=0.
  - data_o is loaded from the assembled register and valid_o is set.
  - If valid_o was already 1 and ready_i=0 in this cycle, overrun_o is set and data_o is overwritten with the new word.
  - Then -> IDLE.
- busy_o=1 in LOW, HIGH and DONE.
- Frame length: DATA_W rising edges on shift_clk_o. Latency from start_i to valid_o = 2*HALF_PER*DATA_W + 1 cycles.
- Handshake:
  - valid_o clears on the cycle after valid_o&&ready_i.
  - A DONE load in the same cycle as an accept leaves valid_o=1 with the new data, and no overrun is flagged.
  - data_o is stable while valid_o=1, except for the overrun overwrite.
- start_i while busy_o=1 is ignored; it is not queued.
- clr_overrun_i clears overrun_o. If clear and set happen in the same cycle, set wins.
- Shift direction:
  - MSB_FIRST=1: shift left, new bit enters at bit 0.
  - MSB_FIRST=0: shift right, new bit enters at bit DATA_W-1.

Optional Feature:
Macro TSENSE_SR_PARITY_EN.
- Defined:
  - The frame carries one extra trailing bit, making DATA_W+1 shift_clk_o pulses; the extra bit is even parity over the data bits.
  - In DONE, parity_err_o is loaded with (XOR of data bits) ^ parity bit. It updates with every completed word and resets to 0.
  - Latency becomes 2*HALF_PER*(DATA_W+1)+1.
- Not defined: frames are exactly DATA_W bits and parity_err_o is tied to 0.

Decomposition:
- Shared package tsense_sr_pkg:
  - FSM state encoding (IDLE, LOW, HIGH, DONE).
  - Frame-length constant derived from DATA_W and TSENSE_SR_PARITY_EN.
  - Minimum HALF_PER constant (3).
- One sub-module: tsense_sync2, a generic 2-flop synchroniser with async active-high reset, used for sr_in.

Test Plan:
- DATA_W=16, HALF_PER=4, sender model returns 0xA5C3 MSB first -> exactly 16 shift_clk_o pulses, each 4 cycles high; valid_o rises 129 cycles after start_i; data_o=0xA5C3.
- Same frame with MSB_FIRST=0 and the sender LSB first -> data_o=0xA5C3.
- Complete 0x1234 with ready_i held 0, start again with 0x00FF -> data_o=0x00FF, overrun_o=1. Pulse clr_overrun_i -> overrun_o=0.
- Pulse start_i at cycle 10 of a frame -> frame unaffected, exactly 16 pulses, a single valid.
- Assert wb_rst_i at bit 7 -> shift_clk_o=0, busy_o=0, valid_o=0 immediately. A new start then reads a full 0xBEEF correctly.
- With TSENSE_SR_PARITY_EN, send 0x0001 with parity bit 0 -> 17 pulses, parity_err_o=1. Resend 0x0001 with parity bit 1 -> parity_err_o=0.
